// File: rtl/sect283r1_pt_unload.sv
`default_nettype none
// ============================================================================
// Module   : sect283r1_pt_unload
// Desc     : Captures the 283-bit affine result (x, y) of sect283r1_pt_mul on
//            the rising edge of done and streams it out as 32-bit words over a
//            valid/ready handshake. Sticky ovf flags results dropped while a
//            previous stream is still draining.
//            Optional macro SECT283R1_PT_UNLOAD_INF_HDR_EN prepends one header
//            word {31'b0, inf}, where inf marks the point at infinity (x=y=0).
// Revision : 1.0 - initial release
// ============================================================================
module sect283r1_pt_unload #(
    parameter int MSW_FIRST = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          done,
    input  logic [282:0]  x,
    input  logic [282:0]  y,
    output logic [31:0]   m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy,
    output logic          ovf
);

`ifdef SECT283R1_PT_UNLOAD_INF_HDR_EN
    localparam logic [4:0] LAST_IDX = 5'd18;
`else
    localparam logic [4:0] LAST_IDX = 5'd17;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           done_q;
    logic [565:0]   hold_q, hold_d;     // {y, x}
    logic [4:0]     cnt_q, cnt_d;
    logic [31:0]    m_data_q, m_data_d;
    logic           m_last_q, m_last_d;
    logic           ovf_q, ovf_d;
`ifdef SECT283R1_PT_UNLOAD_INF_HDR_EN
    logic           inf_q, inf_d;
`endif

    logic           trig;
    logic           hs;
    logic           final_hs;
    logic           capture;
    logic [31:0]    word;

    assign trig     = done & ~done_q;
    assign hs       = (state_q == ST_SEND) & m_ready;
    assign final_hs = hs & (cnt_q == LAST_IDX);

    // Coordinate word p (0..17): p<9 selects x, otherwise y. The 4-bit
    // subtraction wraps 9..17 onto 0..8 without widening the index.
    function automatic logic [31:0] coord_word(input logic [565:0] h, input logic [4:0] p);
        logic [287:0] c;
        logic [3:0]   k;
        if (p < 5'd9) begin
            c = {5'b0, h[282:0]};
            k = p[3:0];
        end else begin
            c = {5'b0, h[565:283]};
            k = p[3:0] - 4'd9;
        end
        if (MSW_FIRST != 0) begin
            k = 4'd8 - k;
        end
        return c[{k, 5'b0} +: 32];
    endfunction

    // Next-state, capture, counter and flag logic; clr overrides everything.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        capture = 1'b0;
`ifdef SECT283R1_PT_UNLOAD_INF_HDR_EN
        inf_d   = inf_q;
`endif
        if (clr) begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trig) begin
                        capture = 1'b1;
                    end
                end
                ST_SEND: begin
                    if (hs) begin
                        if (cnt_q == LAST_IDX) begin
                            if (trig) begin
                                capture = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                    if (trig && !final_hs) begin
                        ovf_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (capture) begin
                hold_d  = {y, x};
                cnt_d   = 5'd0;
                state_d = ST_SEND;
`ifdef SECT283R1_PT_UNLOAD_INF_HDR_EN
                inf_d   = (x == '0) && (y == '0);
`endif
            end
        end
    end

    // Output word for the next cycle, taken from next-state values so the
    // registered m_data lines up with the counter.
    always_comb begin
`ifdef SECT283R1_PT_UNLOAD_INF_HDR_EN
        if (cnt_d == 5'd0) begin
            word = {31'b0, inf_d};
        end else begin
            word = coord_word(hold_d, cnt_d - 5'd1);
        end
`else
        word = coord_word(hold_d, cnt_d);
`endif
        m_data_d = (state_d == ST_SEND) ? word : m_data_q;
        m_last_d = (state_d == ST_SEND) && (cnt_d == LAST_IDX);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            hold_q   <= '0;
            cnt_q    <= 5'd0;
            m_data_q <= 32'd0;
            m_last_q <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef SECT283R1_PT_UNLOAD_INF_HDR_EN
            inf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            done_q   <= done;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            m_data_q <= m_data_d;
            m_last_q <= m_last_d;
            ovf_q    <= ovf_d;
`ifdef SECT283R1_PT_UNLOAD_INF_HDR_EN
            inf_q    <= inf_d;
`endif
        end
    end

    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign m_valid = (state_q == ST_SEND);
    assign busy    = (state_q == ST_SEND);
    assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sect283r1_pt_unload.sv
`default_nettype none
// ============================================================================
// Module   : tb_sect283r1_pt_unload
// Desc     : Self-checking bench for sect283r1_pt_unload. A queue-based model
//            of the word stream is compared against the DUT every cycle, and
//            directed tests pin the model with hand-written word lists.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sect283r1_pt_unload;

    localparam int P_MSW = 0;
`ifdef SECT283R1_PT_UNLOAD_INF_HDR_EN
    localparam int NW  = 19;
    localparam bit HDR = 1'b1;
`else
    localparam int NW  = 18;
    localparam bit HDR = 1'b0;
`endif

    logic         clk, rst_n, clr, done, m_ready;
    logic [282:0] x, y;
    logic [31:0]  m_data;
    logic         m_valid, m_last, busy, ovf;

    sect283r1_pt_unload #(.MSW_FIRST(P_MSW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .done(done),
        .x(x), .y(y),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; logic l; } wd_t;
    wd_t exp_q[$];   // words still owed by the current stream
    wd_t log_q[$];   // words the DUT actually handed over
    wd_t lit_q[$];   // hand-written expectation
    logic ovf_e;
    logic pd;
    int total = 0;
    int bad   = 0;

    localparam logic [282:0] ONES = {283{1'b1}};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Build the expected word list of one point from plain shifts.
    task automatic push_point(input logic [282:0] xv, input logic [282:0] yv);
        wd_t e;
        logic [287:0] c;
        int k;
        e.l = 1'b0;
        if (HDR) begin
            e.d = {31'b0, (xv == '0) && (yv == '0)};
            exp_q.push_back(e);
        end
        for (int s = 0; s < 2; s++) begin
            c = (s == 0) ? {5'b0, xv} : {5'b0, yv};
            for (int i = 0; i < 9; i++) begin
                k = (P_MSW != 0) ? 8 - i : i;
                e.d = 32'(c >> (32 * k));
                exp_q.push_back(e);
            end
        end
        exp_q[exp_q.size() - 1].l = 1'b1;
    endtask

    // Model: follows done edges, handshakes and clr at each active edge.
    initial begin
        logic hs, tr;
        pd = 1'b0;
        ovf_e = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                pd = 1'b0;
                ovf_e = 1'b0;
            end else begin
                hs = (exp_q.size() != 0) && m_ready;
                tr = done && !pd;
                pd = done;
                if (clr) begin
                    exp_q.delete();
                    ovf_e = 1'b0;
                end else begin
                    if (hs) void'(exp_q.pop_front());
                    if (tr) begin
                        if (exp_q.size() == 0) push_point(x, y);
                        else ovf_e = 1'b1;
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, DUT against the model.
    initial begin
        wd_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_valid", {31'b0, m_valid}, 32'd0);
                chk("rst_last",  {31'b0, m_last},  32'd0);
                chk("rst_busy",  {31'b0, busy},    32'd0);
                chk("rst_ovf",   {31'b0, ovf},     32'd0);
                chk("rst_data",  m_data,           32'd0);
            end else begin
                chk("valid", {31'b0, m_valid}, {31'b0, exp_q.size() != 0});
                chk("busy",  {31'b0, busy},    {31'b0, exp_q.size() != 0});
                chk("ovf",   {31'b0, ovf},     {31'b0, ovf_e});
                if (exp_q.size() != 0) begin
                    chk("data", m_data, exp_q[0].d);
                    chk("last", {31'b0, m_last}, {31'b0, exp_q[0].l});
                end else begin
                    chk("last_idle", {31'b0, m_last}, 32'd0);
                end
                if (m_valid && m_ready) begin
                    e.d = m_data;
                    e.l = m_last;
                    log_q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [282:0] xv, input logic [282:0] yv);
        x = xv;
        y = yv;
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        @(negedge clk);
        chk("drain_idle", {31'b0, m_valid}, 32'd0);
    endtask

    task automatic cmp_log(input string name);
        chk({name, "_count"}, log_q.size(), lit_q.size());
        for (int i = 0; i < lit_q.size() && i < log_q.size(); i++) begin
            chk({name, "_word"}, log_q[i].d, lit_q[i].d);
            chk({name, "_lastflag"}, {31'b0, log_q[i].l}, {31'b0, i == lit_q.size() - 1});
        end
    endtask

    task automatic lit_push(input logic [31:0] d, input int n);
        wd_t e;
        e.d = d;
        e.l = 1'b0;
        for (int i = 0; i < n; i++) lit_q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; clr = 1'b0; done = 1'b0; m_ready = 1'b0;
        x = '0; y = '0;

        // Hand-written stream for x=1, y=all ones (header 0 when enabled).
        if (HDR) lit_push(32'h0000_0000, 1);
        lit_push(32'h0000_0001, 1);
        lit_push(32'h0000_0000, 8);
        lit_push(32'hFFFF_FFFF, 8);
        lit_push(32'h07FF_FFFF, 1);
        lit_q[lit_q.size() - 1].l = 1'b1;

        // Reset
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_valid", {31'b0, m_valid}, 32'd0);
        end
        chk("post_rst_data", m_data, 32'd0);

        // Basic stream
        m_ready = 1'b1;
        step();
        log_q.delete();
        pulse(283'h1, ONES);
        @(negedge clk);
        chk("first_word_latency", {31'b0, m_valid}, 32'd1);
        wait_idle(60);
        cmp_log("basic");

        // Backpressure
        log_q.delete();
        x = 283'h1; y = ONES; done = 1'b1;
        step();
        done = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            m_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        m_ready = 1'b1;
        wait_idle(10);
        cmp_log("bp");

        // Overrun at word 5
        log_q.delete();
        pulse(283'h1, ONES);
        repeat (5) step();
        x = 283'h5; y = 283'h6; done = 1'b1;
        step();
        done = 1'b0;
        @(negedge clk);
        chk("ovf_set", {31'b0, ovf}, 32'd1);
        wait_idle(60);
        cmp_log("overrun");
        chk("ovf_sticky", {31'b0, ovf}, 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        @(negedge clk);
        chk("clr_ovf", {31'b0, ovf}, 32'd0);
        chk("clr_valid", {31'b0, m_valid}, 32'd0);

        // Clear mid-stream
        pulse(283'h77, 283'h88);
        repeat (3) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        @(negedge clk);
        chk("clr_mid_valid", {31'b0, m_valid}, 32'd0);

        // Back-to-back: new done edge on the final handshake
        step();
        pulse(283'h1, ONES);
        repeat (NW - 1) step();
        x = 283'h1234_89AB_CDEF; y = 283'h42; done = 1'b1;
        step();
        done = 1'b0;
        @(negedge clk);
        chk("b2b_valid", {31'b0, m_valid}, 32'd1);
        chk("b2b_word0", m_data, HDR ? 32'h0000_0000 : 32'h89AB_CDEF);
        chk("b2b_ovf", {31'b0, ovf}, 32'd0);
        wait_idle(60);

        // Reset mid-stream aborts
        pulse(283'h9, 283'hA);
        repeat (4) step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", {31'b0, m_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_mid_no_resume", {31'b0, m_valid}, 32'd0);

        // done already high at reset release triggers one capture
        rst_n = 1'b0;
        x = 283'hDEAD_BEEF; y = 283'h3;
        done = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("done_high_release", {31'b0, m_valid}, 32'd1);
        wait_idle(60);
        done = 1'b0;
        step();

`ifdef SECT283R1_PT_UNLOAD_INF_HDR_EN
        // Point at infinity header
        lit_q.delete();
        lit_push(32'h0000_0001, 1);
        lit_push(32'h0000_0000, 18);
        lit_q[lit_q.size() - 1].l = 1'b1;
        log_q.delete();
        pulse('0, '0);
        wait_idle(60);
        cmp_log("inf_hdr");
`endif

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sect283r1_pt_unload.md
# sect283r1_pt_unload

Downstream drain stage for `sect283r1_pt_mul`. It captures the 283-bit affine result (x, y) when the multiplier finishes and streams it out as 32-bit words over a valid/ready handshake. This lets a narrow bus or FIFO consume the point without holding the multiplier outputs. It also flags results that arrive while a previous stream is still draining.

## Interface

Parameters:
- `MSW_FIRST`, default 0: 0 sends each coordinate least-significant word first; 1 sends it most-significant word first.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low.
- `clr`  in  1  synchronous clear; same meaning as on `sect283r1_pt_mul`.
- `done`  in  1  multiplier done level, connects to `sect283r1_pt_mul.done`.
- `x`  in  283  affine x; valid while `done`=1.
- `y`  in  283  affine y; valid while `done`=1.
- `m_data`  out  32  output word.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  consumer accepts the word.
- `m_last`  out  1  final word of the point.
- `busy`  out  1  a stream is in progress.
- `ovf`  out  1  sticky flag: a result was dropped.

## Operation

Trigger:
- `done_q` registers `done` every cycle, including during `clr`.
- `trig` = `done & ~done_q`, i.e. a rising edge of `done`.

States:
- IDLE: `m_valid`=0, `busy`=0.
  - On `trig`, capture x and y into a 566-bit holding register, zero the word counter, go to SEND.
- SEND: `m_valid`=1, `busy`=1.
  - Each handshake (`m_valid & m_ready`) increments the word counter (0..17).
  - The handshake on word 17 returns the block to IDLE.

Word mapping, with k = 0..8:
- Coordinate word k = {zero pad, coord[32k+31 : 32k]}.
- Word 8 = {5'b0, coord[282:256]}.
- `MSW_FIRST`=0: stream order is x word 0..8, then y word 0..8.
- `MSW_FIRST`=1: stream order is x word 8..0, then y word 8..0.

Outputs and flags:
- `m_last`=1 only while the final word is presented.
- `trig` while in SEND and not on the final handshake: the new result is dropped and `ovf` sets to 1. The current stream continues unchanged.
- `trig` in the same cycle as the final handshake: the new result is captured and SEND restarts at word 0. `m_valid` stays 1 with no gap. `ovf` is unaffected.
- `clr`: return to IDLE, `m_valid`=0, `m_last`=0, `ovf`=0. `clr` has priority over `trig`.

## Timing

Reset values:
- `m_data`=0, `m_valid`=0, `m_last`=0, `busy`=0, `ovf`=0.
- `done_q`=0, so a `done` that is already high after reset release triggers one capture.

Latency and throughput:
- `trig` sampled at edge N: the first word is valid after edge N, with `m_valid`=1 in cycle N+1.
- With `m_ready` held at 1, 18 words take 18 cycles. `busy` falls the cycle after the last handshake.

Handshake rules:
- While `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` hold stable.
- `m_valid` never drops before the last handshake, except on `clr` or reset.
- `m_data` is driven from a register; there is no combinational path from `m_ready` to `m_data`.
- `ovf` rises the cycle after the dropping `trig`.
- Reset asserted mid-stream aborts it immediately. No partial stream resumes after reset.

## Configuration

Macro: `SECT283R1_PT_UNLOAD_INF_HDR_EN`.
- Defined:
  - Every stream starts with one header word {31'b0, inf}.
  - `inf` = (x==0 && y==0), evaluated on the captured values; this is the multiplier's point-at-infinity encoding.
  - A stream is 19 words; `m_last` is on word 18, and the word counter spans 0..18.
- Undefined:
  - No header; 18 words, as above.
  - No zero-compare logic is synthesized.

## Test plan

- Reset: hold `rst_n`=0 with `done`=0, then release. All outputs read 0 and `m_valid` stays 0 for 10 cycles.
- Basic stream: `MSW_FIRST`=0, x=283'h1, y=all ones, `m_ready`=1, pulse `done`.
  - 18 consecutive words from cycle N+1: 0x00000001, then 8×0x00000000, then 8×0xFFFFFFFF, then 0x07FFFFFF.
  - `m_last` is high only on word 17.
- Backpressure: same data with `m_ready` pseudo-random (about 50%). `m_data` holds stable across every stall, the word sequence is identical to the basic stream, and there are exactly 18 handshakes.
- Overrun: second `done` rising edge at word 5. `ovf`=1 from the next cycle and the original 18 words are unchanged. Then pulse `clr`: `ovf`=0, `m_valid`=0.
- Back-to-back: `done` rising edge in the same cycle as the word-17 handshake. `m_valid` stays 1 and the next cycle shows word 0 of the new x. `ovf` stays 0.
- `SECT283R1_PT_UNLOAD_INF_HDR_EN` defined, x=y=0: 0x00000001 followed by 18×0x00000000, with `m_last` on word 18. With x=1, the header is 0x00000000.
